eth_tx_pack: RTL

//  Ethernet Tx packer: takes raw user payload bytes on an AXI-stream slave, prepends a
//  14-byte Ethernet II header (dst MAC, src MAC, EtherType), zero-pads short frames to the

---
 rtl/eth_tx_pack.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/eth_tx_pack.sv
// Ethernet II Tx packer: prepends dst/src MAC + EtherType to user payload, zero-pads
// short frames to MIN_PAYLOAD and streams the result through a single output register.
module eth_tx_pack #(
    parameter logic [47:0] PACK_DST_ADDR = 48'hAABBCCDDEEFF,
    parameter logic [47:0] PACK_SRC_ADDR = 48'h001122334455,
    parameter logic [15:0] ETH_TYPE      = 16'h88B5,
    parameter int unsigned MIN_PAYLOAD   = 46
) (
    input  logic        i_axi_tx_clk,
    input  logic        i_axi_tx_rst,
    input  logic [7:0]  i_axi_tx_tdata,
    input  logic        i_axi_tx_data_tvalid,
    output logic        o_axi_tx_data_tready,
    input  logic        i_axi_tx_data_tlast,
    output logic [7:0]  o_tx_axis_fifo_tdata,
    output logic        o_tx_axis_fifo_tvalid,
    input  logic        i_tx_axis_fifo_tready,
    output logic        o_tx_axis_fifo_tlast,
    output logic [15:0] o_frame_cnt
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StHeader  = 2'd1;
    localparam logic [1:0] StPayload = 2'd2;
    localparam logic [1:0] StPad     = 2'd3;

    localparam logic [111:0] Header   = {PACK_DST_ADDR, PACK_SRC_ADDR, ETH_TYPE};
    localparam logic [6:0]   MinPay   = 7'(MIN_PAYLOAD);

    logic [1:0]  state_q, state_d;
    logic [3:0]  hdr_idx_q, hdr_idx_d;
    logic [5:0]  pay_cnt_q, pay_cnt_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        slot_free;
    logic [7:0]  hdr_byte;
    logic [5:0]  pay_inc;
    logic [6:0]  pay_next;

    always_comb begin
        slot_free = ~tvalid_q | i_tx_axis_fifo_tready;
        // Header byte 0 is the MSB of the concatenated header
        hdr_byte  = 8'(Header >> (7'd8 * (7'd13 - {3'b000, hdr_idx_q})));
        pay_inc   = (pay_cnt_q == 6'd63) ? pay_cnt_q : pay_cnt_q + 6'd1;
        pay_next  = {1'b0, pay_cnt_q} + 7'd1;
        o_axi_tx_data_tready = (state_q == StPayload) & slot_free;
    end

    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        pay_cnt_d   = pay_cnt_q;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        tvalid_d    = slot_free ? 1'b0 : tvalid_q;
        frame_cnt_d = frame_cnt_q;

        if (tvalid_q & tlast_q & i_tx_axis_fifo_tready) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (slot_free) begin
            case (state_q)
                StIdle: begin
                    if (i_axi_tx_data_tvalid) begin
                        tdata_d   = Header[111:104];
                        tvalid_d  = 1'b1;
                        tlast_d   = 1'b0;
                        hdr_idx_d = 4'd1;
                        state_d   = StHeader;
                    end
                end
                StHeader: begin
                    tdata_d  = hdr_byte;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    if (hdr_idx_q == 4'd13) begin
                        pay_cnt_d = 6'd0;
                        state_d   = StPayload;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end
                end
                StPayload: begin
                    if (i_axi_tx_data_tvalid) begin
                        tdata_d   = i_axi_tx_tdata;
                        tvalid_d  = 1'b1;
                        tlast_d   = 1'b0;
                        pay_cnt_d = pay_inc;
                        if (i_axi_tx_data_tlast) begin
                            if (pay_next >= MinPay) begin
                                tlast_d = 1'b1;
                                state_d = StIdle;
                            end else begin
                                state_d = StPad;
                            end
                        end
                    end
                end
                StPad: begin
                    tdata_d   = 8'h00;
                    tvalid_d  = 1'b1;
                    tlast_d   = 1'b0;
                    pay_cnt_d = pay_inc;
                    if (pay_next >= MinPay) begin
                        tlast_d = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_axi_tx_clk or posedge i_axi_tx_rst) begin
        if (i_axi_tx_rst) begin
            state_q     <= StIdle;
            hdr_idx_q   <= 4'd0;
            pay_cnt_q   <= 6'd0;
            tdata_q     <= 8'h00;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            pay_cnt_q   <= pay_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_tx_axis_fifo_tdata  = tdata_q;
    assign o_tx_axis_fifo_tvalid = tvalid_q;
    assign o_tx_axis_fifo_tlast  = tlast_q;
    assign o_frame_cnt           = frame_cnt_q;

endmodule
